alu_issue_arbiter: RTL and testbench
====================================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares the single ALU execute stage between two requesters: port 0 is the decode path and
//  port 1 is the debug/exception path. Each request carries operands, ALU_OP, funct and regD.
//  The block arbitrates, drives the ALU with stable inputs for LAT cycles, captures the result,
//  and returns it through a valid/ready response channel. It sits between decode and writeback.
// PARAMETERS
//  DATA_W   32  operand/result width
//  FUNCT_W  6   funct field width (instruction bits [5:0])
//  LAT      1   ALU stage result latency in cycles; must be >= 1
// PORTS
//  clk           in   1        system clock, rising edge
//  reset         in   1        asynchronous, active-low (0 = in reset)
//  reqN_valid    in   1        N=0,1: request valid
//  reqN_ready    out  1        N=0,1: request accepted this cycle
//  reqN_alu_op   in   2        N=0,1: ALU_OP class (2'b10 = R-type, use funct)
//  reqN_funct    in   FUNCT_W  N=0,1: function code
//  reqN_a        in   DATA_W   N=0,1: regA data
//  reqN_b        in   DATA_W   N=0,1: regB data
//  reqN_regD     in   5        N=0,1: destination register
//  alu_a/alu_b   out  DATA_W   operands to ALU stage
//  alu_op        out  2        ALU_OP to ALU stage
//  alu_funct     out  FUNCT_W  funct to ALU stage
//  alu_result    in   DATA_W   regDdata from ALU stage
//  alu_zero      in   1        zero flag from ALU stage
//  rsp_valid     out  1        response valid
//  rsp_ready     in   1        response consumer ready
//  rsp_id        out  1        requester that owns the response
//  rsp_data      out  DATA_W   captured alu_result
//  rsp_zero      out  1        captured alu_zero
//  rsp_regD      out  5        regD of the granted request
// BEHAVIOUR
//  - FSM states: IDLE -> EXEC -> RESP -> IDLE. Reset state is IDLE.
//  - IDLE: if any reqN_valid is high, grant one requester. reqN_ready is high combinationally
//    for the granted N only, and only in IDLE. On that edge, latch a/b/op/funct/regD/id,
//    load cnt=LAT-1, and go to EXEC. With no valid request, stay in IDLE; all readys are 0.
//  - EXEC: drive alu_* from the latched registers, held stable the whole time. Decrement cnt.
//    When cnt==0, capture alu_result/alu_zero into rsp_data/rsp_zero and go to RESP.
//  - RESP: rsp_valid=1. rsp_* stay stable until rsp_valid&&rsp_ready, then go to IDLE.
//    A new grant is possible on the next cycle, not the same cycle.
//  - Timing: accept at cycle t; EXEC for cycles t+1..t+LAT; rsp_valid first high at t+LAT+1.
//    Minimum issue interval is LAT+2 cycles.
//  - alu_* outputs hold the last latched values in IDLE and RESP; they are 0 after reset.
//  - Reset value of every output is 0, including reqN_ready, rsp_valid and rsp_*.
//  - Reset asserted mid-operation: the operation is aborted and dropped with no response.
//    The FSM returns to IDLE and the round-robin pointer returns to favour port 0.
//  - Requesters must hold their fields stable while valid && !ready. A requester that drops
//    valid before being granted is not served.
//  - Widths: no arithmetic here except cnt, which is $clog2(LAT+1) bits and never wraps.
// CONFIGURATION
//  ALU_ARB_RR_EN defined: round-robin arbitration. The last granted port has the lowest
//    priority. The pointer updates only on a grant; after reset it favours port 0.
//  ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins. Port 1 can starve.
//    No pointer register is built.
// TESTING
//  1 req0 a=1 b=1 op=2'b10 funct=6'h01 (ADD), LAT=1 -> req0_ready at t, rsp_valid at t+2,
//    rsp_data=2, rsp_zero=0, rsp_id=0.
//  2 req0 a=1 b=1 funct=6'h00 (SUB) -> rsp_data=0, rsp_zero=1.
//  3 req0 and req1 held valid together (a=0x11, b=0x21, ADD), RR build -> grants go 0,1,0,1.
//    Each rsp_data=0x32. Fixed build -> only port 0 is granted.
//  4 rsp_ready held low 3 cycles in RESP -> rsp_valid and rsp_data stay stable, no new
//    readys. Back to IDLE on the cycle after rsp_ready=1.
//  5 reset=0 pulsed during EXEC -> all outputs go to 0 immediately, no response is issued,
//    and the next request is accepted normally.
//  6 LAT=3 with ADD 5+7 -> alu_* stable for 3 cycles, rsp_valid at t+4, rsp_data=12.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: two-port issue arbiter in front of the shared ALU stage.
// Define ALU_ARB_RR_EN for round-robin; default build is fixed priority.
module alu_issue_arbiter #(
  parameter int DATA_W  = 32,
  parameter int FUNCT_W = 6,
  parameter int LAT     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [1:0]         req0_alu_op,
  input  logic [FUNCT_W-1:0] req0_funct,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [4:0]         req0_regD,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [1:0]         req1_alu_op,
  input  logic [FUNCT_W-1:0] req1_funct,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [4:0]         req1_regD,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [1:0]         alu_op,
  output logic [FUNCT_W-1:0] alu_funct,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_zero,
  output logic [4:0]         rsp_regD
);

  localparam int CNT_W = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [1:0]         op_q, op_d;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic [4:0]         regd_q, regd_d;
  logic               id_q, id_d;
  logic               zero_q, zero_d;
  logic               any_req;
  logic               gnt_id;

  assign any_req = req0_valid | req1_valid;

`ifdef ALU_ARB_RR_EN
  // prio_q names the favoured port; it flips away from each winner
  logic prio_q, prio_d;

  always_comb begin
    gnt_id = 1'b0;
    unique case (1'b1)
      req0_valid && req1_valid:  gnt_id = prio_q;
      !req0_valid && req1_valid: gnt_id = 1'b1;
      default:                   gnt_id = 1'b0;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (state_q == IDLE && any_req)
      prio_d = ~gnt_id;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`else
  assign gnt_id = ~req0_valid;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    funct_d    = funct_q;
    regd_d     = regd_q;
    id_d       = id_q;
    data_d     = data_q;
    zero_d     = zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          // readys stay low while reset is asserted
          req0_ready = reset & ~gnt_id;
          req1_ready = reset & gnt_id;
          a_d        = gnt_id ? req1_a : req0_a;
          b_d        = gnt_id ? req1_b : req0_b;
          op_d       = gnt_id ? req1_alu_op : req0_alu_op;
          funct_d    = gnt_id ? req1_funct : req0_funct;
          regd_d     = gnt_id ? req1_regD : req0_regD;
          id_d       = gnt_id;
          cnt_d      = CNT_INIT;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          data_d  = alu_result;
          zero_d  = alu_zero;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      funct_q <= '0;
      regd_q  <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      regd_q  <= regd_d;
      id_q    <= id_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_funct = funct_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_zero  = zero_q;
  assign rsp_regD  = regd_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: table vectors plus scoreboard for alu_issue_arbiter.
// Drives a LAT=1 instance and a LAT=3 instance.
module tb_alu_issue_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        r0v, r0r, r1v, r1r;
  logic [1:0]  r0op, r1op;
  logic [5:0]  r0f, r1f;
  logic [31:0] r0a, r0b, r1a, r1b;
  logic [4:0]  r0d, r1d;
  logic [31:0] aa, ab, ares;
  logic [1:0]  aop;
  logic [5:0]  af;
  logic        az;
  logic        rv, rr, rid, rz;
  logic [31:0] rdata;
  logic [4:0]  rregd;

  logic        v0_3, v1_3, r0r3, r1r3;
  logic [31:0] aa3, ab3, ares3;
  logic [1:0]  aop3;
  logic [5:0]  af3;
  logic        az3;
  logic        rv3, rr3, rid3, rz3;
  logic [31:0] rdata3;
  logic [4:0]  rregd3;

  // external ALU stage seen by the arbiter
  function automatic logic [31:0] alu_f(
    input logic [1:0] op, input logic [5:0] f,
    input logic [31:0] a, input logic [31:0] b);
    if (op != 2'b10) return a + b;
    case (f)
      6'h00:   return a - b;
      6'h01:   return a + b;
      6'h02:   return a & b;
      6'h03:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign ares  = alu_f(aop, af, aa, ab);
  assign az    = (ares == 32'd0);
  assign ares3 = alu_f(aop3, af3, aa3, ab3);
  assign az3   = (ares3 == 32'd0);

  alu_issue_arbiter #(.DATA_W(32), .FUNCT_W(6), .LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(r0r), .req0_alu_op(r0op),
    .req0_funct(r0f), .req0_a(r0a), .req0_b(r0b), .req0_regD(r0d),
    .req1_valid(r1v), .req1_ready(r1r), .req1_alu_op(r1op),
    .req1_funct(r1f), .req1_a(r1a), .req1_b(r1b), .req1_regD(r1d),
    .alu_a(aa), .alu_b(ab), .alu_op(aop), .alu_funct(af),
    .alu_result(ares), .alu_zero(az),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid),
    .rsp_data(rdata), .rsp_zero(rz), .rsp_regD(rregd)
  );

  alu_issue_arbiter #(.DATA_W(32), .FUNCT_W(6), .LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(v0_3), .req0_ready(r0r3), .req0_alu_op(r0op),
    .req0_funct(r0f), .req0_a(r0a), .req0_b(r0b), .req0_regD(r0d),
    .req1_valid(v1_3), .req1_ready(r1r3), .req1_alu_op(r1op),
    .req1_funct(r1f), .req1_a(r1a), .req1_b(r1b), .req1_regD(r1d),
    .alu_a(aa3), .alu_b(ab3), .alu_op(aop3), .alu_funct(af3),
    .alu_result(ares3), .alu_zero(az3),
    .rsp_valid(rv3), .rsp_ready(rr3), .rsp_id(rid3),
    .rsp_data(rdata3), .rsp_zero(rz3), .rsp_regD(rregd3)
  );

  typedef struct {
    bit          p;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [5:0]  f;
    logic [4:0]  d;
    logic [31:0] ed;
    logic        ez;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        zero;
    logic [4:0]  regd;
  } exp_t;

  exp_t sb[$];
  exp_t sb3[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && rv && rr) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", 64'(rdata), 64'(e.data));
        check("rsp_zero", 64'(rz), 64'(e.zero));
        check("rsp_id", 64'(rid), 64'(e.id));
        check("rsp_regD", 64'(rregd), 64'(e.regd));
      end
    end
  end

  always @(negedge clk) begin
    if (reset && rv3 && rr3) begin
      if (sb3.size() == 0) begin
        check("rsp3_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb3.pop_front();
        check("rsp3_data", 64'(rdata3), 64'(e.data));
        check("rsp3_zero", 64'(rz3), 64'(e.zero));
      end
    end
  end

  task automatic set_port(input vec_t v);
    if (!v.p) begin
      r0v = 1'b1; r0a = v.a; r0b = v.b;
      r0op = v.op; r0f = v.f; r0d = v.d;
    end else begin
      r1v = 1'b1; r1a = v.a; r1b = v.b;
      r1op = v.op; r1f = v.f; r1d = v.d;
    end
  endtask

  // single request on one port; returns at the negedge with rsp_valid high
  task automatic issue(input vec_t v);
    int   n;
    int   m;
    bit   got;
    exp_t e;
    @(posedge clk); #1;
    set_port(v);
    n = 0; got = 0;
    while (!got && n < 8) begin
      @(negedge clk); n++;
      if ((v.p ? r1r : r0r) === 1'b1) got = 1;
    end
    check("grant_wait", 64'(n), 64'd1);
    check("other_ready", 64'(v.p ? r0r : r1r), 64'd0);
    e.id = v.p; e.data = v.ed; e.zero = v.ez; e.regd = v.d;
    if (got) sb.push_back(e);
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0;
    m = 0; got = 0;
    while (!got && m < 10) begin
      @(negedge clk); m++;
      if (m == 1) check("ready_exec", 64'(r0r | r1r), 64'd0);
      if (rv === 1'b1) got = 1;
    end
    check("rsp_latency", 64'(m), 64'd2);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  vec_t tv[7];
  vec_t vx;
  exp_t ex;
  int   cnt;
  int   m;
  bit   got;
  bit   gid;
  bit   exp_gid;

  initial begin
    tv[0] = '{0, 32'd1, 32'd1, 2'b10, 6'h01, 5'd5, 32'd2, 1'b0};
    tv[1] = '{0, 32'd1, 32'd1, 2'b10, 6'h00, 5'd6, 32'd0, 1'b1};
    tv[2] = '{1, 32'h11, 32'h21, 2'b10, 6'h01, 5'd7, 32'h32, 1'b0};
    tv[3] = '{1, 32'hFFFF_FFFF, 32'd1, 2'b10, 6'h01, 5'd31, 32'd0, 1'b1};
    tv[4] = '{0, 32'hF0F0, 32'h0FF0, 2'b10, 6'h02, 5'd1, 32'h00F0, 1'b0};
    tv[5] = '{1, 32'd5, 32'd7, 2'b00, 6'h3F, 5'd2, 32'd12, 1'b0};
    tv[6] = '{0, 32'hA5, 32'h5A, 2'b10, 6'h03, 5'd0, 32'hFF, 1'b0};

    reset = 1'b0; rr = 1'b1; rr3 = 1'b1;
    r0v = 1'b1; r1v = 1'b0; v0_3 = 1'b0; v1_3 = 1'b0;
    r0a = '0; r0b = '0; r0op = '0; r0f = '0; r0d = '0;
    r1a = '0; r1b = '0; r1op = '0; r1f = '0; r1d = '0;
    #2;
    check("rst_req0_ready", 64'(r0r), 64'd0);
    check("rst_rsp_valid", 64'(rv), 64'd0);
    check("rst_alu_a", 64'(aa), 64'd0);
    check("rst_rsp_data", 64'(rdata), 64'd0);
    check("rst_rsp_regD", 64'(rregd), 64'd0);
    r0v = 1'b0;
    #10 reset = 1'b1;

    for (int i = 0; i < 7; i++) issue(tv[i]);
    drain();

    // backpressure: response held, waiting port 1 not granted
    rr = 1'b0;
    vx = '{0, 32'd3, 32'd4, 2'b10, 6'h01, 5'd9, 32'd7, 1'b0};
    issue(vx);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) set_port('{1, 32'd2, 32'd2, 2'b10, 6'h00,
                             5'd10, 32'd0, 1'b1});
      @(negedge clk);
      check("hold_valid", 64'(rv), 64'd1);
      check("hold_data", 64'(rdata), 64'd7);
      check("hold_no_ready", 64'(r0r | r1r), 64'd0);
    end
    @(posedge clk); #1 rr = 1'b1;
    @(negedge clk);
    check("hs_no_same_grant", 64'(r1r), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_hs_grant", 64'(r1r), 64'd1);
    check("post_hs_idle", 64'(rv), 64'd0);
    ex = '{1'b1, 32'd0, 1'b1, 5'd10};
    sb.push_back(ex);
    @(posedge clk); #1 r1v = 1'b0;
    drain();

    // reset pulse during EXEC drops the operation
    @(posedge clk); #1;
    set_port('{0, 32'd9, 32'd9, 2'b10, 6'h01, 5'd12, 32'd18, 1'b0});
    @(negedge clk);
    check("abort_grant", 64'(r0r), 64'd1);
    @(posedge clk); #1 r0v = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("abort_alu_a", 64'(aa), 64'd0);
    check("abort_alu_funct", 64'(af), 64'd0);
    check("abort_rsp_regD", 64'(rregd), 64'd0);
    check("abort_rsp_valid", 64'(rv), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rv) cnt++;
    end
    check("abort_no_rsp", 64'(cnt), 64'd0);

    // both ports held valid: arbitration order
    @(posedge clk); #1;
    set_port('{0, 32'h11, 32'h21, 2'b10, 6'h01, 5'd3, 32'h32, 1'b0});
    set_port('{1, 32'h11, 32'h21, 2'b10, 6'h01, 5'd4, 32'h32, 1'b0});
    for (int k = 0; k < 4; k++) begin
      got = 0; m = 0;
      while (!got && m < 10) begin
        @(negedge clk); m++;
        if (r0r | r1r) got = 1;
      end
      check("arb_grant_seen", 64'(got), 64'd1);
      check("arb_one_hot", 64'(r0r & r1r), 64'd0);
      gid = r1r;
`ifdef ALU_ARB_RR_EN
      exp_gid = k[0];
`else
      exp_gid = 1'b0;
`endif
      check("arb_grant_id", 64'(gid), 64'(exp_gid));
      ex = '{gid, 32'h32, 1'b0, gid ? 5'd4 : 5'd3};
      if (got) sb.push_back(ex);
      @(posedge clk);
    end
    #1 r0v = 1'b0; r1v = 1'b0;
    drain();

    // LAT=3 instance: operands held for three EXEC cycles
    @(posedge clk); #1;
    r0a = 32'd5; r0b = 32'd7; r0op = 2'b10; r0f = 6'h01; r0d = 5'd13;
    v0_3 = 1'b1;
    @(negedge clk);
    check("lat3_grant", 64'(r0r3), 64'd1);
    ex = '{1'b0, 32'd12, 1'b0, 5'd13};
    if (r0r3) sb3.push_back(ex);
    @(posedge clk); #1 v0_3 = 1'b0;
    got = 0; m = 0;
    while (!got && m < 10) begin
      @(negedge clk); m++;
      if (rv3) got = 1;
      else check("lat3_alu_hold", {aa3, ab3}, {32'd5, 32'd7});
    end
    check("lat3_latency", 64'(m), 64'd4);
    for (int i = 0; i < 10 && sb3.size() != 0; i++) @(negedge clk);
    check("drain3", 64'(sb3.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
